// File: rtl/slice_pkg.sv
// slice_pkg: shared definitions for the memory-capable logic slice.
//   - LUT mode encodings (2 bits per LUT in the config vector).
//   - Config-vector field offsets, all in terms of K (inputs per LUT) and
//     N (number of LUTs). Field order from the LSB: LUT memories, modes,
//     use_cc, reg_init.
package slice_pkg;

   typedef enum logic [1:0] {
      MODE_LUT = 2'b00,
      MODE_RAM = 2'b01,
      MODE_SRL = 2'b10,
      MODE_RSV = 2'b11   // reserved, behaves as MODE_LUT
   } lut_mode_e;

   // Bit offset of LUT i's memory.
   function automatic int cfg_lut_base(int k, int i);
      return i * (1 << k);
   endfunction

   // Bit offset of LUT i's 2-bit mode field.
   function automatic int cfg_mode_base(int k, int n, int i);
      return n * (1 << k) + 2 * i;
   endfunction

   // Bit offset of the carry-chain enable.
   function automatic int cfg_cc_bit(int k, int n);
      return n * (1 << k) + 2 * n;
   endfunction

   // Bit offset of the N output-register initial values (the MSBs).
   function automatic int cfg_init_base(int k, int n);
      return cfg_cc_bit(k, n) + 1;
   endfunction

   // Total config-chain length.
   function automatic int cfg_bits(int k, int n);
      return cfg_init_base(k, n) + n;
   endfunction

endpackage

// File: rtl/slicem_lut.sv
// slicem_lut: one K-input LUT cell of the slice.
//   Holds 2^K memory bits and a 2-bit mode. Both are segments of the
//   serial config chain (shifted toward bit 0 while cen=1). In operation
//   the cell acts as a plain LUT, a distributed RAM (write mem[addr]) or a
//   shift register (new bit enters at tap 0). Reads are combinational.
// Ports:
//   clk, rst         fabric clock, async active-high reset
//   cen              1 = shift config, 0 = operate
//   we, di           write/shift enable and data bit
//   addr             read/write address (K bits)
//   mem_sin/mem_sout config chain through the memory bits
//   mode_sin/mode_sout config chain through the mode bits
//   lut_o            mem[addr]
module slicem_lut
   import slice_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cen,
   input  logic         we,
   input  logic         di,
   input  logic [K-1:0] addr,
   input  logic         mem_sin,
   output logic         mem_sout,
   input  logic         mode_sin,
   output logic         mode_sout,
   output logic         lut_o
);

   localparam int DEPTH = 1 << K;

   logic [DEPTH-1:0] mem;
   logic [1:0]       mode;

   // NOTE: the LUT memory is configuration state, so it is cleared by reset
   // like every other config bit; a reset mid-load must leave no residue.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, which the shift and SRL paths depend on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem  <= '0;
         mode <= MODE_LUT;
      end else if (cen) begin
         // Config shift takes priority over any write.
         mem  <= {mem_sin, mem[DEPTH-1:1]};
         mode <= {mode_sin, mode[1]};
      end else if (we) begin
         case (mode)
            MODE_RAM: mem[addr] <= di;
            MODE_SRL: mem       <= {mem[DEPTH-2:0], di};
            default:  ;  // LUT and reserved modes are read-only
         endcase
      end
   end

   assign lut_o     = mem[addr];
   assign mem_sout  = mem[0];
   assign mode_sout = mode[0];

endmodule

// File: rtl/slicem.sv
// slicem: memory-capable logic slice.
//   NUM_LUTS K-input LUTs (each LUT, RAM or SRL), an optional ripple carry
//   chain, and per-LUT output registers with configurable initial values.
//   Config is one serial chain on clk, enabled by cen; cfg_out = cfg[0].
// Ports:
//   clk, rst   fabric clock, async active-high reset
//   cen        1 = shift config chain, 0 = operate
//   cfg_in     serial config input (enters at the MSB, reg_init)
//   cfg_out    serial config output (LUT0 memory bit 0)
//   luts_in    LUT i address at luts_in[i*K +: K]
//   we, di     write/shift enable and per-LUT data
//   reg_ce     output register enable
//   Ci, Co     carry in / carry out
//   out        combinational outputs
//   sync_out   registered outputs
module slicem
   import slice_pkg::*;
#(
   parameter int LUT_INPUTS = 4,
   parameter int NUM_LUTS   = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cen,
   input  logic                           cfg_in,
   output logic                           cfg_out,
   input  logic [LUT_INPUTS*NUM_LUTS-1:0] luts_in,
   input  logic                           we,
   input  logic [NUM_LUTS-1:0]            di,
   input  logic                           reg_ce,
   input  logic                           Ci,
   output logic                           Co,
   output logic [NUM_LUTS-1:0]            out,
   output logic [NUM_LUTS-1:0]            sync_out
);

   localparam int K = LUT_INPUTS;
   localparam int N = NUM_LUTS;

   // Global config bits above the LUT cells in the chain.
   logic         use_cc;
   logic [N-1:0] reg_init;

   logic [N-1:0] mem_si, mem_so;
   logic [N-1:0] mode_si, mode_so;
   logic [N-1:0] lut_p;
   logic [N:0]   carry;

   // Chain order (MSB to LSB): reg_init, use_cc, modes N-1..0, mems N-1..0.
   for (genvar i = 0; i < N; i++) begin : g_lut
      if (i == N - 1) begin : g_top
         assign mode_si[i] = use_cc;
         assign mem_si[i]  = mode_so[0];
      end else begin : g_mid
         assign mode_si[i] = mode_so[i+1];
         assign mem_si[i]  = mem_so[i+1];
      end

      slicem_lut #(.K(K)) u_lut (
         .clk       (clk),
         .rst       (rst),
         .cen       (cen),
         .we        (we),
         .di        (di[i]),
         .addr      (luts_in[i*K +: K]),
         .mem_sin   (mem_si[i]),
         .mem_sout  (mem_so[i]),
         .mode_sin  (mode_si[i]),
         .mode_sout (mode_so[i]),
         .lut_o     (lut_p[i])
      );
   end

   assign cfg_out = mem_so[0];

   // Carry chain: LUT output is propagate, LUT input 0 is generate.
   // NOTE: every output of this block gets a default first, so no path
   // through it can infer a latch.
   always_comb begin
      carry    = '0;
      out      = '0;
      Co       = 1'b0;
      carry[0] = Ci;
      for (int i = 0; i < N; i++) begin
         carry[i+1] = lut_p[i] ? carry[i] : luts_in[i*K];
      end
      if (!cen) begin
         if (use_cc) begin
            out = lut_p ^ carry[N-1:0];
            Co  = carry[N];
         end else begin
            out = lut_p;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         use_cc   <= 1'b0;
         reg_init <= '0;
         sync_out <= '0;
      end else if (cen) begin
         use_cc   <= reg_init[0];
         reg_init <= {cfg_in, reg_init[N-1:1]};
         // Registers track the init value while loading.
         sync_out <= reg_init;
      end else if (reg_ce) begin
         sync_out <= out;
      end
   end

endmodule

// File: tb/tb_slicem.sv
// tb_slicem: self-checking bench for slicem at default parameters.
// A behavioural model keeps the whole 77-bit config vector as one array and
// applies the shift / write / register rules to it; a compare process
// checks every DUT output against it on each falling edge. Directed tests
// pin the model with hand-computed literals; a random phase follows.
module tb_slicem;

   localparam int K  = 4;
   localparam int N  = 4;
   localparam int D  = 16;
   localparam int CB = 77;
   localparam int MODE_B = 64;
   localparam int CC_B   = 72;
   localparam int INIT_B = 73;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cen = 1'b0;
   logic          cfg_in = 1'b0;
   logic          cfg_out;
   logic [K*N-1:0] luts_in = '0;
   logic          we = 1'b0;
   logic [N-1:0]  di = '0;
   logic          reg_ce = 1'b0;
   logic          Ci = 1'b0;
   logic          Co;
   logic [N-1:0]  out;
   logic [N-1:0]  sync_out;

   int n_checks = 0;
   int n_errors = 0;

   slicem #(.LUT_INPUTS(K), .NUM_LUTS(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .cfg_in   (cfg_in),
      .cfg_out  (cfg_out),
      .luts_in  (luts_in),
      .we       (we),
      .di       (di),
      .reg_ce   (reg_ce),
      .Ci       (Ci),
      .Co       (Co),
      .out      (out),
      .sync_out (sync_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [CB-1:0] m_cfg;
   logic [N-1:0]  m_sync;

   function automatic void model_comb(output logic [N-1:0] o, output logic co);
      logic [N-1:0] p;
      logic c;
      for (int i = 0; i < N; i++) p[i] = m_cfg[i*D + int'(luts_in[i*K +: K])];
      o  = '0;
      co = 1'b0;
      c  = Ci;
      if (!cen) begin
         if (m_cfg[CC_B]) begin
            for (int i = 0; i < N; i++) begin
               o[i] = p[i] ^ c;
               c    = p[i] ? c : luts_in[i*K];
            end
            co = c;
         end else begin
            o = p;
         end
      end
   endfunction

   always @(posedge clk or posedge rst) begin : model
      logic [N-1:0] o;
      logic co;
      logic [1:0] md;
      int a;
      if (rst) begin
         m_cfg  = '0;
         m_sync = '0;
      end else if (cen) begin
         m_sync = m_cfg[INIT_B +: N];
         m_cfg  = {cfg_in, m_cfg[CB-1:1]};
      end else begin
         model_comb(o, co);
         if (reg_ce) m_sync = o;
         if (we) begin
            for (int i = 0; i < N; i++) begin
               md = m_cfg[MODE_B + 2*i +: 2];
               a  = int'(luts_in[i*K +: K]);
               if (md == 2'b01) m_cfg[i*D + a] = di[i];
               else if (md == 2'b10) m_cfg[i*D +: D] = {m_cfg[i*D +: D-1], di[i]};
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] eo;
      logic eco;
      model_comb(eo, eco);
      check("out", out, eo);
      check("Co", Co, eco);
      check("sync_out", sync_out, m_sync);
      check("cfg_out", cfg_out, m_cfg[0]);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CB-1:0] make_cfg(input logic [15:0] m0, input logic [15:0] m1,
                                              input logic [15:0] m2, input logic [15:0] m3,
                                              input logic [7:0] modes, input logic cc,
                                              input logic [3:0] init);
      return {init, cc, modes, m3, m2, m1, m0};
   endfunction

   function automatic logic [K*N-1:0] ab(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [K*N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         v[i*K]   = a[i];
         v[i*K+1] = b[i];
      end
      return v;
   endfunction

   task automatic shift_cfg(input logic [CB-1:0] v);
      cen = 1'b1;
      for (int i = 0; i < CB; i++) begin
         cfg_in = v[i];
         tick();
      end
      cen = 1'b0;
      cfg_in = 1'b0;
   endtask

   task automatic readback(input int rst_at);
      cen = 1'b1;
      for (int i = 0; i < CB; i++) begin
         cfg_in = cfg_out;
         if (i == rst_at) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
            cfg_in = cfg_out;
         end
         tick();
      end
      cen = 1'b0;
      cfg_in = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // 1. reset with arbitrary inputs
      luts_in = 16'hA5C3; di = 4'hF; we = 1'b1; reg_ce = 1'b1; Ci = 1'b1;
      tick(); tick();
      check("rst_out", out, 4'b0000);
      check("rst_sync", sync_out, 4'b0000);
      check("rst_Co", Co, 1'b0);
      check("rst_cfg_out", cfg_out, 1'b0);
      rst = 1'b0; cen = 1'b0;
      tick();
      check("post_rst_out", out, 4'b0000);
      check("post_rst_sync", sync_out, 4'b0000);
      we = 1'b0; reg_ce = 1'b0; Ci = 1'b0; di = '0;

      // 2. LUT mode
      shift_cfg(make_cfg(16'h8000, 16'h0, 16'h0, 16'h0, 8'h00, 1'b0, 4'b1010));
      luts_in = 16'h000F;
      #1 check("lut_and_out", out, 4'b0001);
      reg_ce = 1'b1;
      tick();
      reg_ce = 1'b0;
      check("lut_reg_sync", sync_out, 4'b0001);

      // 3. RAM mode on LUT1
      shift_cfg(make_cfg(16'h8000, 16'h0, 16'h0, 16'h0, 8'b0000_0100, 1'b0, 4'b0000));
      luts_in = 16'h0050; di = 4'b0010; we = 1'b1;
      #1 check("ram_old_read", out[1], 1'b0);
      tick();
      we = 1'b0; di = '0;
      #1 check("ram_addr5", out[1], 1'b1);
      luts_in = 16'h0040;
      #1 check("ram_addr4", out[1], 1'b0);
      luts_in = 16'h005F;
      #1 check("ram_lut0_kept", out, 4'b0011);

      // 6. readback keeps RAM contents; reset mid-readback clears config
      readback(-1);
      luts_in = 16'h0050;
      #1 check("rb_ram_addr5", out[1], 1'b1);
      readback(30);
      luts_in = 16'h0050;
      #1 check("rb_rst_out", out, 4'b0000);
      luts_in = 16'hFFFF;
      #1 check("rb_rst_out_ff", out, 4'b0000);
      check("rb_rst_sync", sync_out, 4'b0000);

      // 4. SRL mode on LUT2
      shift_cfg(make_cfg(16'h0, 16'h0, 16'h0, 16'h0, 8'b0010_0000, 1'b0, 4'b0000));
      we = 1'b1;
      di = 4'b0100; tick();
      di = 4'b0000; tick();
      di = 4'b0100; tick();
      di = 4'b0100; tick();
      we = 1'b0; di = '0;
      luts_in = 16'h0000; #1 check("srl_tap0", out[2], 1'b1);
      luts_in = 16'h0100; #1 check("srl_tap1", out[2], 1'b1);
      luts_in = 16'h0200; #1 check("srl_tap2", out[2], 1'b0);
      luts_in = 16'h0300; #1 check("srl_tap3", out[2], 1'b1);

      // 5. carry chain, every LUT = in0 ^ in1
      shift_cfg(make_cfg(16'h6666, 16'h6666, 16'h6666, 16'h6666, 8'h00, 1'b1, 4'b0000));
      Ci = 1'b0; luts_in = ab(4'b0111, 4'b0001);
      #1 check("cc1_out", out, 4'b1000);
      check("cc1_Co", Co, 1'b0);
      luts_in = ab(4'b1111, 4'b0001);
      #1 check("cc2_out", out, 4'b0000);
      check("cc2_Co", Co, 1'b1);
      Ci = 1'b1; luts_in = ab(4'b0000, 4'b0000);
      #1 check("cc3_out", out, 4'b0001);
      check("cc3_Co", Co, 1'b0);
      Ci = 1'b0;
      tick();

      // random phase
      for (int r = 0; r < 4; r++) begin
         logic [CB-1:0] rc;
         rc = {$urandom, $urandom, $urandom};
         shift_cfg(rc);
         for (int c = 0; c < 250; c++) begin
            luts_in = 16'($urandom);
            di      = 4'($urandom);
            we      = 1'($urandom_range(0, 1));
            reg_ce  = 1'($urandom_range(0, 1));
            Ci      = 1'($urandom_range(0, 1));
            cfg_in  = 1'($urandom_range(0, 1));
            cen     = ($urandom_range(0, 31) == 0);
            if (r == 2 && c == 120) begin
               rst = 1'b1;
               #1;
               rst = 1'b0;
            end
            tick();
         end
         cen = 1'b0; we = 1'b0;
      end

      tick(); tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
